// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with clock filter, ack check and timeout
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 100,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       ar,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);
    localparam int M1   = INHIBIT_CYCLES > SETUP_CYCLES ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int MAXC = TIMEOUT_CYCLES > M1 ? TIMEOUT_CYCLES : M1;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, XFER, ACK, WAIT_IDLE} state_t;

    state_t        r_st;
    logic [7:0]    r_sr;
    logic          r_fclk;
    logic          r_fall;
    logic [1:0]    r_ds;
    logic [8:0]    r_sh;
    logic [3:0]    r_edge;
    logic [CW-1:0] r_cnt;
    logic          r_nack;
    logic          r_clk_oe;
    logic          r_dat_oe;
    logic          r_done;
    logic          r_err;
    logic          r_to;
    logic          w_dat;
    logic          w_tmo;

    assign w_dat      = r_ds[1];
    assign w_tmo      = r_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign tx_ready   = r_st == IDLE;
    assign busy       = r_st != IDLE;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign done       = r_done;
    assign ack_err    = r_err;
    assign timeout    = r_to;

    always_ff @(posedge clk) begin
        if (ar) begin
            r_st     <= IDLE;
            r_sr     <= 8'hFF;
            r_fclk   <= 1'b1;
            r_fall   <= 1'b0;
            r_ds     <= 2'b11;
            r_sh     <= '0;
            r_edge   <= '0;
            r_cnt    <= '0;
            r_nack   <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_sr   <= {r_sr[6:0], ps2_clk};
            r_fclk <= &r_sr ? 1'b1 : ~|r_sr ? 1'b0 : r_fclk;
            r_fall <= r_fclk & ~|r_sr;
            r_ds   <= {r_ds[0], ps2_dat};
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_to   <= 1'b0;
            unique case (r_st)
                IDLE: if (tx_valid) begin
                    r_sh     <= {~^tx_data, tx_data};
                    r_clk_oe <= 1'b1;
                    r_cnt    <= '0;
                    r_st     <= INHIBIT;
                end
                INHIBIT: if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    r_cnt    <= '0;
                    r_dat_oe <= 1'b1;
                    r_st     <= RTS;
                end else r_cnt <= r_cnt + 1'b1;
                RTS: if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
                    r_cnt    <= '0;
                    r_edge   <= '0;
                    r_clk_oe <= 1'b0;
                    r_st     <= XFER;
                end else r_cnt <= r_cnt + 1'b1;
                XFER, ACK, WAIT_IDLE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_tmo) begin
                        r_to     <= 1'b1;
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_st     <= IDLE;
                    end else if (r_st == XFER && r_fall) begin
                        r_edge <= r_edge + 1'b1;
                        if (r_edge == 4'd9) begin
                            r_dat_oe <= 1'b0;
                            r_st     <= ACK;
                        end else begin
                            // data bits LSB first, parity shifts down into bit 0 after eight edges
                            r_dat_oe <= ~r_sh[0];
                            r_sh     <= {1'b0, r_sh[8:1]};
                        end
                    end else if (r_st == ACK && r_fall) begin
                        r_nack <= w_dat;
                        r_st   <= WAIT_IDLE;
                    end else if (r_st == WAIT_IDLE && r_fclk && w_dat) begin
                        r_done <= ~r_nack;
                        r_err  <= r_nack;
                        r_st   <= IDLE;
                    end
                end
                default: r_st <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, 5000, clk cycles ps2_clk_oe is held asserted before the request-to-send (100 us at 50 MHz).
REQ-002 Parameter SETUP_CYCLES, 100, clk cycles ps2_clk_oe and ps2_dat_oe are both asserted before ps2_clk_oe releases.
REQ-003 Parameter TIMEOUT_CYCLES, 750000, maximum clk cycles from ps2_clk_oe release to end of transaction (15 ms at 50 MHz).
REQ-004 Ports:
- clk  in  1  system clock; all logic on its rising edge.
- ar  in  1  reset; synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock line.
- ps2_dat  in  1  raw PS/2 data line.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  send request.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_oe  out  1  1 = drive PS/2 clock low (open drain); 0 = release.
- ps2_dat_oe  out  1  1 = drive PS/2 data low; 0 = release.
- busy  out  1  high in every state except IDLE; lets the top level gate the receiver.
- done  out  1  one-cycle pulse on acknowledged completion.
- ack_err  out  1  one-cycle pulse when the device does not acknowledge.
- timeout  out  1  one-cycle pulse on timeout abort.

Function
REQ-005 ps2_clk filtering uses an 8-bit shift register.
- Filtered clock goes to 1 after 8 consecutive high samples and to 0 after 8 consecutive low samples; otherwise it holds.
- fall_pulse asserts for one cycle on each 1->0 transition of the filtered clock.
REQ-006 ps2_dat passes through a 2-flop synchronizer before any use.
REQ-007 States: IDLE, INHIBIT, RTS, XFER, ACK, WAIT_IDLE.
REQ-008 Handshake: transfer is accepted when tx_valid and tx_ready are both high. The module then latches tx_data and the odd parity bit (~^tx_data) and moves to INHIBIT.
REQ-009 tx_valid is ignored in every state other than IDLE.
REQ-010 INHIBIT: ps2_clk_oe=1 and ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-011 RTS: ps2_clk_oe=1 and ps2_dat_oe=1 (start bit) for exactly SETUP_CYCLES cycles, then go to XFER. ps2_clk_oe=0 from XFER entry onward.
REQ-012 XFER uses a 4-bit edge counter, cleared on XFER entry and incremented per fall_pulse.
- Falling edges 1..8 set ps2_dat_oe = ~tx_data[n-1] (LSB first).
- Falling edge 9 sets ps2_dat_oe = ~parity.
- Falling edge 10 sets ps2_dat_oe=0 (stop bit); go to ACK.
REQ-013 ACK: on the next fall_pulse, sample synchronized ps2_dat.
- 0 = acknowledged; 1 = NACK (recorded).
- Go to WAIT_IDLE.
REQ-014 WAIT_IDLE: when filtered clock=1 and synchronized data=1, pulse done (acknowledged) or ack_err (NACK), exactly one of them, and go to IDLE.
REQ-015 Timeout counter:
- Cleared on XFER entry; counts every cycle in XFER, ACK and WAIT_IDLE.
- On reaching TIMEOUT_CYCLES: pulse timeout, set both oe=0, go to IDLE. done and ack_err do not pulse.
REQ-016 If completion and timeout occur in the same cycle, timeout takes priority.
REQ-017 ps2_clk_oe and ps2_dat_oe are registered outputs; no combinational path from any input to them.
REQ-018 Transaction end to tx_ready=1 is exactly one cycle.
REQ-019 A fall_pulse in IDLE, INHIBIT or RTS has no effect.

Reset
REQ-020 While ar=1 at a clk edge, the block resets:
- state=IDLE, tx_ready=1, busy=0.
- ps2_clk_oe=0, ps2_dat_oe=0, done=ack_err=timeout=0.
- Filter register all ones; filtered clock=1.
- Counters=0; the latched byte is discarded.
REQ-021 Reset mid-transaction releases both lines on the first clk edge with ar=1. No pulse output asserts.

Verification
REQ-022 Send 0xED; device model clocks and acks -> clk_oe high 5100 cycles, dat_oe high for the last 100 of them. Bits on line 1,0,1,1,0,1,1,1, parity 1, stop released. done pulses once; tx_ready=1 one cycle later.
REQ-023 Send 0x01 -> parity bit on line 0. Send 0x00 -> parity 1. Both done.
REQ-024 Device leaves data high at edge 11 -> ack_err pulses once after bus idle; done stays 0.
REQ-025 Device never clocks after release -> timeout pulses exactly 750000 cycles after clk_oe falls. Both oe=0; tx_ready=1 next cycle.
REQ-026 ar asserted after edge 4 of XFER -> next edge both oe=0 and tx_ready=1. A 5-cycle low glitch on ps2_clk after release does not advance the edge count.
REQ-027 tx_valid=1 with tx_data=0xFF during INHIBIT -> ignored; the original byte completes unchanged.
